seg_entry_ctrl: RTL and testbench

SEG_ENTRY_CTRL -- requirements
Module: seg_entry_ctrl

---
 rtl/seg_entry_ctrl.sv | 156 +++++++++++++++
 tb/tb_seg_entry_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_entry_ctrl.sv
// Two-button hex digit entry for a seven-segment display: SHIFT mode pushes
// digits in from the right, EDIT mode overwrites a blinking cursor digit.
package myPkg;
    // Active-low segments, bit order {dp,g,f,e,d,c,b,a}; decimal point off.
    function automatic logic [7:0] seg_drv(input logic [3:0] v);
        logic [7:0] p;
        case (v)
            4'h0: p = 8'hC0;
            4'h1: p = 8'hF9;
            4'h2: p = 8'hA4;
            4'h3: p = 8'hB0;
            4'h4: p = 8'h99;
            4'h5: p = 8'h92;
            4'h6: p = 8'h82;
            4'h7: p = 8'hF8;
            4'h8: p = 8'h80;
            4'h9: p = 8'h90;
            4'hA: p = 8'h88;
            4'hB: p = 8'h83;
            4'hC: p = 8'hC6;
            4'hD: p = 8'hA1;
            4'hE: p = 8'h86;
            default: p = 8'h8E;
        endcase
        return p;
    endfunction
endpackage

module seg_entry_ctrl #(
    parameter int          NUM_SEG      = 6,
    parameter int          DEBOUNCE_CYC = 500000,
    parameter int          BLINK_CYC    = 12500000,
    parameter logic [7:0]  SEG_BLANK    = 8'hFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       btn,
    input  logic                       btn_mode,
    input  logic [3:0]                 sw,
    output logic [7:0]                 seg [0:NUM_SEG-1],
    output logic                       mode,
    output logic [$clog2(NUM_SEG)-1:0] cursor
);
    localparam int CW = $clog2(NUM_SEG);
    localparam int DW = $clog2(DEBOUNCE_CYC);
    localparam int BW = $clog2(BLINK_CYC);
    localparam logic [DW-1:0] DB_TC   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [BW-1:0] BL_TC   = BW'(BLINK_CYC - 1);
    localparam logic [CW-1:0] CUR_MAX = CW'(NUM_SEG - 1);

    // state | meaning
    // SHIFT | entry press shifts sw into digit 0, cursor frozen
    // EDIT  | entry press writes sw at cursor, cursor advances; cursor digit blinks
    typedef enum logic {SHIFT = 1'b0, EDIT = 1'b1} state_e;

    logic [1:0]    btn_a;
    logic [1:0]    meta_q, sync_q, stable_q, press_q;
    logic [DW-1:0] db_cnt_q [2];

    assign btn_a = {btn_mode, btn};

    // Bit 0 = entry button, bit 1 = mode button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q   <= '1;
            sync_q   <= '1;
            stable_q <= '1;
            press_q  <= '0;
            for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
        end else begin
            meta_q <= btn_a;
            sync_q <= meta_q;
            for (int b = 0; b < 2; b++) begin
                press_q[b] <= 1'b0;
                if (sync_q[b] == stable_q[b]) begin
                    db_cnt_q[b] <= '0;
                end else if (db_cnt_q[b] == DB_TC) begin
                    db_cnt_q[b] <= '0;
                    stable_q[b] <= sync_q[b];
                    press_q[b]  <= ~sync_q[b];
                end else begin
                    db_cnt_q[b] <= db_cnt_q[b] + DW'(1);
                end
            end
        end
    end

    state_e        state_q;
    logic [CW-1:0] cursor_q;
    logic [BW-1:0] blink_cnt_q;
    logic          blink_q;
    logic [3:0]    digit_q [NUM_SEG];
    logic [3:0]    digit_d [NUM_SEG];
    logic [7:0]    seg_q   [NUM_SEG];
    logic          ent_ev, mode_ev;

    // A mode press wins over a coincident entry press.
    assign mode_ev = press_q[1];
    assign ent_ev  = press_q[0] & ~press_q[1];

    always_comb begin
        for (int i = 0; i < NUM_SEG; i++) digit_d[i] = digit_q[i];
        if (ent_ev) begin
            if (state_q == SHIFT) begin
                digit_d[0] = sw;
                for (int i = 1; i < NUM_SEG; i++) digit_d[i] = digit_q[i-1];
            end else begin
                for (int i = 0; i < NUM_SEG; i++)
                    if (cursor_q == CW'(i)) digit_d[i] = sw;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SHIFT;
            cursor_q    <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (mode_ev) begin
            state_q     <= (state_q == SHIFT) ? EDIT : SHIFT;
            if (state_q == SHIFT) cursor_q <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            if (ent_ev && state_q == EDIT)
                cursor_q <= (cursor_q == CUR_MAX) ? '0 : cursor_q + CW'(1);
            if (blink_cnt_q == BL_TC) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                digit_q[i] <= 4'h0;
                seg_q[i]   <= myPkg::seg_drv(4'h0);
            end
        end else begin
            for (int i = 0; i < NUM_SEG; i++) begin
                digit_q[i] <= digit_d[i];
                seg_q[i]   <= (state_q == EDIT && blink_q && cursor_q == CW'(i))
                              ? SEG_BLANK : myPkg::seg_drv(digit_q[i]);
            end
        end
    end

    assign seg    = seg_q;
    assign mode   = (state_q == EDIT);
    assign cursor = cursor_q;

endmodule

// File: tb/tb_seg_entry_ctrl.sv
// Randomized scoreboard bench for seg_entry_ctrl: transactions update an
// operation-level model whose expected display state is queued for a monitor.
module tb_seg_entry_ctrl;
    localparam int NS = 4;
    localparam int DB = 4;
    localparam int BC = 8;
    localparam logic [7:0] BLANK = 8'hFF;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       btn_mode;
    logic [3:0] sw;
    logic [7:0] seg [0:NS-1];
    logic       mode;
    logic [1:0] cursor;

    seg_entry_ctrl #(
        .NUM_SEG(NS), .DEBOUNCE_CYC(DB), .BLINK_CYC(BC), .SEG_BLANK(BLANK)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .btn_mode(btn_mode), .sw(sw),
        .seg(seg), .mode(mode), .cursor(cursor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NS*4-1:0] d;
        logic            mode;
        logic [1:0]      cur;
    } exp_t;

    exp_t       sb_q [$];
    exp_t       mon_e;
    int         n_vec = 0;
    int         n_bad = 0;
    logic [3:0] m_d [NS];
    logic       m_mode;
    int         m_cur;

    function automatic logic [7:0] lit_of(input logic [3:0] v);
        logic [7:0] t [16];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return t[v];
    endfunction

    task automatic check_any(input string name, input logic [7:0] act,
                             input logic [7:0] exp_a, input logic [7:0] exp_b);
        n_vec++;
        if (act !== exp_a && act !== exp_b) begin
            n_bad++;
            if (exp_a === exp_b)
                $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp_a, $time);
            else
                $display("FAIL %s: got %h, want %h or %h (t=%0t)", name, act, exp_a, exp_b, $time);
        end
    endtask

    task automatic cmp_state(input exp_t e);
        logic [7:0] lit;
        check_any("mode", {7'b0, mode}, {7'b0, e.mode}, {7'b0, e.mode});
        check_any("cursor", {6'b0, cursor}, {6'b0, e.cur}, {6'b0, e.cur});
        for (int i = 0; i < NS; i++) begin
            lit = lit_of(e.d[i*4 +: 4]);
            if (e.mode && e.cur == 2'(i))
                check_any($sformatf("seg%0d", i), seg[i], lit, BLANK);
            else
                check_any($sformatf("seg%0d", i), seg[i], lit, lit);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            cmp_state(mon_e);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_d[i] = 4'h0;
        m_mode = 1'b0;
        m_cur  = 0;
    endtask

    task automatic model_entry(input logic [3:0] s);
        if (!m_mode) begin
            for (int i = NS - 1; i > 0; i--) m_d[i] = m_d[i-1];
            m_d[0] = s;
        end else begin
            m_d[m_cur] = s;
            m_cur = (m_cur + 1) % NS;
        end
    endtask

    task automatic model_mode();
        if (!m_mode) m_cur = 0;
        m_mode = !m_mode;
    endtask

    task automatic push_exp();
        exp_t e;
        for (int i = 0; i < NS; i++) e.d[i*4 +: 4] = m_d[i];
        e.mode = m_mode;
        e.cur  = 2'(m_cur);
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit e, input bit m, input logic v);
        if (e) btn = v;
        if (m) btn_mode = v;
    endtask

    // nb short bounces (each too short to qualify), then a low of `hold`
    // cycles, then a release long enough to be debounced back to high.
    task automatic txn(input bit e, input bit m, input logic [3:0] s,
                       input int nb, input int hold);
        sw = s;
        for (int k = 0; k < nb; k++) begin
            drive(e, m, 1'b0);
            idle($urandom_range(1, DB - 1));
            drive(e, m, 1'b1);
            idle($urandom_range(1, 3));
        end
        if (hold > 0) begin
            drive(e, m, 1'b0);
            idle(hold);
        end
        drive(e, m, 1'b1);
        idle(DB + 6);
        if (hold >= DB) begin
            if (m) model_mode();
            else if (e) model_entry(s);
        end
        push_exp();
        idle(2);
    endtask

    task automatic ev_txn(input bit e, input bit m, input logic [3:0] s);
        txn(e, m, s, $urandom_range(0, 2), $urandom_range(DB, DB + 4));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1);
    end

    initial begin
        logic       b, prev;
        int         run, ntrans, waited;
        logic [3:0] s;
        int         op;

        rst = 1'b1; btn = 1'b1; btn_mode = 1'b1; sw = 4'h0;
        model_reset();
        idle(3);
        push_exp();
        idle(2);
        rst = 1'b0;
        idle(2);

        for (int v = 1; v <= 5; v++) ev_txn(1'b1, 1'b0, 4'(v));

        // Bounce that never qualifies, then one long hold.
        sw = 4'hF;
        btn = 1'b0; idle(3); btn = 1'b1; idle(1);
        btn = 1'b0; idle(3); btn = 1'b1; idle(DB + 6);
        push_exp();
        idle(2);
        txn(1'b1, 1'b0, 4'h6, 0, 10);

        ev_txn(1'b0, 1'b1, 4'h0);
        for (int v = 10; v <= 14; v++) ev_txn(1'b1, 1'b0, 4'(v));
        ev_txn(1'b1, 1'b0, 4'h2);

        // EDIT idle with cursor 2: only seg[2] toggles, in runs of BC samples.
        run = 0; ntrans = 0; prev = 1'b0;
        for (int k = 0; k < 4 * BC + 2; k++) begin
            @(negedge clk);
            for (int i = 0; i < NS; i++)
                if (i != 2) check_any($sformatf("steady%0d", i), seg[i], lit_of(m_d[i]), lit_of(m_d[i]));
            check_any("blink_dig", seg[2], lit_of(m_d[2]), BLANK);
            b = (seg[2] === BLANK);
            if (k == 0) begin
                prev = b; run = 1;
            end else if (b != prev) begin
                if (ntrans > 0) check_any("blink_run", 8'(run), 8'(BC), 8'(BC));
                ntrans++; run = 1; prev = b;
            end else begin
                run++;
            end
        end
        check_any("blink_trans", {7'b0, ntrans >= 3}, 8'd1, 8'd1);

        ev_txn(1'b0, 1'b1, 4'h0);
        for (int k = 0; k < 2 * BC + 2; k++) begin
            @(negedge clk);
            for (int i = 0; i < NS; i++)
                check_any($sformatf("noblank%0d", i), seg[i], lit_of(m_d[i]), lit_of(m_d[i]));
        end

        // Entering EDIT restarts blinking lit-first from the mode edge.
        btn_mode = 1'b0;
        waited = 0;
        while (mode !== 1'b1 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check_any("mode_rise", {7'b0, mode}, 8'd1, 8'd1);
        model_mode();
        for (int k = 0; k <= 3 * BC; k++) begin
            if (k == 2) btn_mode = 1'b1;
            if (k > BC && k <= 2 * BC)
                check_any($sformatf("phase%0d", k), seg[0], BLANK, BLANK);
            else
                check_any($sformatf("phase%0d", k), seg[0], lit_of(m_d[0]), lit_of(m_d[0]));
            @(negedge clk);
        end
        idle(DB + 6);
        push_exp();
        idle(2);

        ev_txn(1'b0, 1'b1, 4'h0);
        ev_txn(1'b1, 1'b1, 4'h7);

        for (int t = 0; t < 60; t++) begin
            op = $urandom_range(0, 7);
            s  = 4'($urandom_range(0, 15));
            case (op)
                0, 1, 2, 3: ev_txn(1'b1, 1'b0, s);
                4:          ev_txn(1'b0, 1'b1, s);
                5:          ev_txn(1'b1, 1'b1, s);
                6:          txn(1'b0, 1'b1, s, $urandom_range(0, 2), $urandom_range(0, DB - 1));
                default:    txn(1'b1, 1'b0, s, $urandom_range(0, 2), $urandom_range(1, DB - 1));
            endcase
        end

        // Build d = {9,8,7,6} (d[0]=9) with cursor 3 in EDIT, then reset.
        if (m_mode) ev_txn(1'b0, 1'b1, 4'h0);
        ev_txn(1'b1, 1'b0, 4'h6);
        ev_txn(1'b1, 1'b0, 4'h1);
        ev_txn(1'b1, 1'b0, 4'h2);
        ev_txn(1'b1, 1'b0, 4'h3);
        ev_txn(1'b0, 1'b1, 4'h0);
        ev_txn(1'b1, 1'b0, 4'h9);
        ev_txn(1'b1, 1'b0, 4'h8);
        ev_txn(1'b1, 1'b0, 4'h7);

        btn = 1'b0;
        idle(3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_any("rst_mode", {7'b0, mode}, 8'd0, 8'd0);
        check_any("rst_cursor", {6'b0, cursor}, 8'd0, 8'd0);
        for (int i = 0; i < NS; i++)
            check_any($sformatf("rst_seg%0d", i), seg[i], lit_of(4'h0), lit_of(4'h0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        btn = 1'b1;
        idle(DB + 6);
        push_exp();
        idle(2);
        txn(1'b1, 1'b0, 4'h3, 0, DB + 1);

        waited = 0;
        while (sb_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_any("drain", 8'(sb_q.size()), 8'd0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
